// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Serializer states; a frame walks START -> DATA -> [PAR] -> STOP.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  // Parity modes selectable through the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for a data word; narrower words arrive zero-extended,
  // which leaves the XOR reduction unchanged.
  function automatic logic frame_parity(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Write FIFO for the UART transmit path. Count-based full/empty with all
// status outputs registered; head word is presented combinationally so the
// serializer can load it on the same cycle it pops.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          push_ok, pop_ok;

  // Accept/pop decisions and next-state of pointers, count and flags.
  always_comb begin
    push_ok    = i_push & ~full_q;
    pop_ok     = i_pop & ~empty_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CNT_FULL);
    empty_d    = (count_d == '0);
    overflow_d = i_push & full_q;
  end

  // Pointer, count and status registers; reset empties the queue.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; only accepted writes touch it.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata    = mem[rd_ptr_q];
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: write FIFO feeding a frame serializer that advances
// only on i_baud strobes and chains queued frames without an idle bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_W-1:0]      i_D,
  input  logic                   i_write,
  input  logic                   i_baud,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_busy,
  output logic                   o_tx
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              fifo_empty;

  uart_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wdata    (i_D),
    .i_push     (i_write),
    .i_pop      (pop),
    .o_rdata    (head),
    .o_full     (o_full),
    .o_empty    (fifo_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  // Next-state and line value; nothing moves except on a baud strobe.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (i_baud) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = frame_parity(8'(head), PARITY);
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        PAR: begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end
        STOP: begin
          if (cnt_q == LAST_STOP) begin
            // Chain straight into the next start bit when work is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = frame_parity(8'(head), PARITY);
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Serializer registers; reset aborts any frame and parks the line high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign o_empty = fifo_empty;
  assign o_busy  = (state_q != IDLE);
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances (8N1, 8E2, 8O2)
// compared tick by tick against a queue-based frame model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic [2:0] wr;
  logic       baud;
  logic [2:0] full, empty, ovf, busy, tx;
  logic [4:0] cnt0, cnt1, cnt2;

  int n_cmp = 0;
  int n_err = 0;

  bit exp0[$];
  bit exp1[$];
  bit exp2[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_D(d), .i_write(wr[0]), .i_baud(baud),
    .o_full(full[0]), .o_empty(empty[0]), .o_count(cnt0), .o_overflow(ovf[0]),
    .o_busy(busy[0]), .o_tx(tx[0])
  );

  uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_D(d), .i_write(wr[1]), .i_baud(baud),
    .o_full(full[1]), .o_empty(empty[1]), .o_count(cnt1), .o_overflow(ovf[1]),
    .o_busy(busy[1]), .o_tx(tx[1])
  );

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_D(d), .i_write(wr[2]), .i_baud(baud),
    .o_full(full[2]), .o_empty(empty[2]), .o_count(cnt2), .o_overflow(ovf[2]),
    .o_busy(busy[2]), .o_tx(tx[2])
  );

  // One clock; returns 1 ns after the rising edge so outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int inst, input logic [7:0] w);
    d = w;
    wr = '0;
    wr[inst] = 1'b1;
    cyc();
    wr = '0;
    $display("push dut%0d data=0x%02h", inst, w);
  endtask

  // period-1 quiet cycles then one strobe cycle; period 1 == baud held high.
  task automatic baud_tick(input int period);
    baud = 1'b0;
    repeat (period - 1) cyc();
    baud = 1'b1;
    cyc();
    baud = 1'b0;
  endtask

  // Model: expected line bits of one frame, appended to the chosen queue.
  task automatic add_frame(input int sel, input logic [7:0] w, input int par, input int stop);
    bit f[$];
    int ones;
    f.push_back(1'b0);
    for (int i = 0; i < 8; i++) f.push_back(w[i]);
    ones = $countones(w);
    if (par == 1) f.push_back((ones % 2) == 1);
    if (par == 2) f.push_back((ones % 2) == 0);
    for (int i = 0; i < stop; i++) f.push_back(1'b1);
    foreach (f[i]) begin
      if (sel == 0) exp0.push_back(f[i]);
      else if (sel == 1) exp1.push_back(f[i]);
      else exp2.push_back(f[i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d = '0; wr = '0; baud = 1'b0;
    cyc();
    n_cmp++;
    if ({tx[0], empty[0], full[0], ovf[0], busy[0], cnt0} !== {5'b11000, 5'd0}) begin
      n_err++;
      $display("FAIL reset_state got tx/empty/full/ovf/busy/count=%b want 11000_00000",
               {tx[0], empty[0], full[0], ovf[0], busy[0], cnt0});
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if ({tx[0], empty[0], full[0], ovf[0], busy[0], cnt0} !== {5'b11000, 5'd0}) begin
      n_err++;
      $display("FAIL after_release got %b want 11000_00000",
               {tx[0], empty[0], full[0], ovf[0], busy[0], cnt0});
    end
    // Start a frame, then reset while the start bit is on the line.
    for (int i = 0; i < 3; i++) push_word(0, 8'($urandom));
    baud_tick(1);
    n_cmp++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_start got tx=%b busy=%b want tx=0 busy=1", tx[0], busy[0]);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || cnt0 !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset got tx=%b busy=%b count=%0d want 1 0 0", tx[0], busy[0], cnt0);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (cnt0 !== 5'd0 || empty[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_release got count=%0d empty=%b busy=%b want 0 1 0",
               cnt0, empty[0], busy[0]);
    end
    repeat (12) baud_tick(1);
    n_cmp++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || empty[0] !== 1'b1) begin
      n_err++;
      $display("FAIL discarded_queue got tx=%b busy=%b empty=%b want 1 0 1",
               tx[0], busy[0], empty[0]);
    end
  endtask

  task automatic test_basic_frame();
    int want[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit eb;
    push_word(0, 8'hA5);
    n_cmp++;
    if (cnt0 !== 5'd1 || empty[0] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count got count=%0d empty=%b want 1 0", cnt0, empty[0]);
    end
    for (int k = 0; k <= 10; k++) begin
      baud_tick(16);
      eb = (k < 10) ? want[k][0] : 1'b1;
      n_cmp++;
      if (tx[0] !== eb || busy[0] !== (k < 10)) begin
        n_err++;
        $display("FAIL basic_tick%0d got tx=%b busy=%b want tx=%b busy=%b",
                 k, tx[0], busy[0], eb, (k < 10));
      end
    end
    $display("frame 0xA5 sent on dut0");
  endtask

  task automatic test_back_to_back();
    bit eb;
    exp0.delete();
    push_word(0, 8'h11); add_frame(0, 8'h11, 0, 1);
    push_word(0, 8'h22); add_frame(0, 8'h22, 0, 1);
    n_cmp++;
    if (cnt0 !== 5'd2) begin
      n_err++;
      $display("FAIL b2b_count got %0d want 2", cnt0);
    end
    for (int k = 0; k <= 20; k++) begin
      baud_tick(4);
      eb = (k < 20) ? exp0[k] : 1'b1;
      n_cmp++;
      if (tx[0] !== eb || busy[0] !== (k < 20)) begin
        n_err++;
        $display("FAIL b2b_tick%0d got tx=%b busy=%b want tx=%b busy=%b",
                 k, tx[0], busy[0], eb, (k < 20));
      end
    end
    $display("frames 0x11,0x22 sent on dut0");
  endtask

  task automatic test_parity();
    bit e1, e2;
    exp1.delete(); exp2.delete();
    push_word(1, 8'h07); add_frame(1, 8'h07, 1, 2);
    push_word(2, 8'h07); add_frame(2, 8'h07, 2, 2);
    for (int k = 0; k <= 12; k++) begin
      baud_tick(3);
      e1 = (k < 12) ? exp1[k] : 1'b1;
      e2 = (k < 12) ? exp2[k] : 1'b1;
      n_cmp++;
      if (tx[1] !== e1 || busy[1] !== (k < 12)) begin
        n_err++;
        $display("FAIL even_tick%0d got tx=%b busy=%b want tx=%b busy=%b",
                 k, tx[1], busy[1], e1, (k < 12));
      end
      n_cmp++;
      if (tx[2] !== e2 || busy[2] !== (k < 12)) begin
        n_err++;
        $display("FAIL odd_tick%0d got tx=%b busy=%b want tx=%b busy=%b",
                 k, tx[2], busy[2], e2, (k < 12));
      end
    end
    $display("frame 0x07 sent on dut1 (even,2 stop) and dut2 (odd,2 stop)");
  endtask

  task automatic test_full_overflow();
    bit eb;
    logic [4:0] ec;
    logic [7:0] w;
    exp0.delete();
    for (int i = 0; i < 16; i++) begin
      w = 8'($urandom);
      push_word(0, w);
      add_frame(0, w, 0, 1);
    end
    n_cmp++;
    if (full[0] !== 1'b1 || cnt0 !== 5'd16) begin
      n_err++;
      $display("FAIL fill16 got full=%b count=%0d want 1 16", full[0], cnt0);
    end
    push_word(0, 8'($urandom));
    n_cmp++;
    if (ovf[0] !== 1'b1 || cnt0 !== 5'd16 || full[0] !== 1'b1) begin
      n_err++;
      $display("FAIL overflow got ovf=%b count=%0d full=%b want 1 16 1", ovf[0], cnt0, full[0]);
    end
    cyc();
    n_cmp++;
    if (ovf[0] !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_pulse got ovf=%b want 0", ovf[0]);
    end
    for (int k = 0; k <= 160; k++) begin
      baud_tick(1);
      eb = (k < 160) ? exp0[k] : 1'b1;
      ec = (k < 160) ? 5'(16 - (k / 10 + 1)) : 5'd0;
      n_cmp++;
      if (tx[0] !== eb || busy[0] !== (k < 160) || cnt0 !== ec) begin
        n_err++;
        $display("FAIL full_drain_tick%0d got tx=%b busy=%b count=%0d want %b %b %0d",
                 k, tx[0], busy[0], cnt0, eb, (k < 160), ec);
      end
    end
    $display("16 queued frames drained on dut0, dropped word absent");
  endtask

  task automatic test_collision();
    bit eb;
    logic [4:0] ec;
    logic [7:0] w;
    exp0.delete();
    for (int i = 0; i < 16; i++) begin
      w = 8'($urandom);
      push_word(0, w);
      add_frame(0, w, 0, 1);
    end
    // Write on the pop tick while full: dropped.
    d = 8'($urandom); wr = 3'b001; baud = 1'b1;
    cyc();
    baud = 1'b0;
    n_cmp++;
    if (tx[0] !== 1'b0 || ovf[0] !== 1'b1 || cnt0 !== 5'd15 || full[0] !== 1'b0) begin
      n_err++;
      $display("FAIL collide got tx=%b ovf=%b count=%0d full=%b want 0 1 15 0",
               tx[0], ovf[0], cnt0, full[0]);
    end
    w = 8'($urandom);
    d = w;
    cyc();
    wr = '0;
    add_frame(0, w, 0, 1);
    $display("push dut0 data=0x%02h after collision", w);
    n_cmp++;
    if (cnt0 !== 5'd16 || ovf[0] !== 1'b0 || full[0] !== 1'b1) begin
      n_err++;
      $display("FAIL refill got count=%0d ovf=%b full=%b want 16 0 1", cnt0, ovf[0], full[0]);
    end
    for (int k = 1; k <= 170; k++) begin
      baud_tick(1);
      eb = (k < 170) ? exp0[k] : 1'b1;
      ec = (k < 170) ? 5'(16 - k / 10) : 5'd0;
      n_cmp++;
      if (tx[0] !== eb || busy[0] !== (k < 170) || cnt0 !== ec) begin
        n_err++;
        $display("FAIL collide_drain_tick%0d got tx=%b busy=%b count=%0d want %b %b %0d",
                 k, tx[0], busy[0], cnt0, eb, (k < 170), ec);
      end
    end
    $display("17 frames drained on dut0 after collision");
  endtask

  task automatic test_random();
    bit eb;
    logic [4:0] ec;
    logic [7:0] w;
    int n, period;
    for (int r = 0; r < 4; r++) begin
      exp0.delete();
      n = $urandom_range(1, 16);
      period = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom);
        push_word(0, w);
        add_frame(0, w, 0, 1);
      end
      n_cmp++;
      if (cnt0 !== 5'(n) || full[0] !== (n == 16)) begin
        n_err++;
        $display("FAIL rand%0d_fill got count=%0d full=%b want %0d %b",
                 r, cnt0, full[0], n, (n == 16));
      end
      for (int k = 0; k <= n * 10; k++) begin
        baud_tick(period);
        eb = (k < n * 10) ? exp0[k] : 1'b1;
        ec = (k < n * 10) ? 5'(n - (k / 10 + 1)) : 5'd0;
        n_cmp++;
        if (tx[0] !== eb || busy[0] !== (k < n * 10) || cnt0 !== ec) begin
          n_err++;
          $display("FAIL rand%0d_tick%0d got tx=%b busy=%b count=%0d want %b %b %0d",
                   r, k, tx[0], busy[0], cnt0, eb, (k < n * 10), ec);
        end
      end
      $display("random round %0d: %0d frames, baud period %0d", r, n, period);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_parity();
    test_full_overflow();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
